// File: rtl/cam_pkg.sv
// Shared definitions for the camera PLL supervisor.
// Holds the supervisor state encoding and the default cycle constants
// (16 MHz reference clock).
package cam_pkg;

  localparam logic [1:0] S_PLL_RST   = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  typedef enum logic [1:0] {
    PLL_RST   = S_PLL_RST,
    WAIT_LOCK = S_WAIT_LOCK,
    STABLE    = S_STABLE,
    RUN       = S_RUN
  } sup_state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 16000;  // 1 ms at 16 MHz
  localparam int DEF_LOCK_STABLE    = 256;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/cam_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (async active-low, clears both flops to 0),
//        d (asynchronous input), q (synchronised output, 2-edge latency).
module cam_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cam_pll_sup.sv
// PLL supervisor and system reset generator, clocked by the 16 MHz reference.
// Holds the PLL in reset, waits for lock, requires lock to be stable before
// releasing the 40 MHz system reset, and retries the PLL on timeout or loss.
// Ports:
//   clk        16 MHz reference clock
//   rst_n      async active-low reset
//   pll_lock   PLL LOCK (asynchronous to clk)
//   pll_rst_n  active-low reset to the PLL
//   sys_rst_n  active-low system reset for the 40 MHz domain
//   pll_ok     high while in RUN
//   retry_cnt  saturating count of timeouts plus lock losses
module cam_pll_sup
  import cam_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst_n,
  output logic       sys_rst_n,
  output logic       pll_ok,
  output logic [7:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

  logic lock_s;

  cam_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  sup_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             pll_rst_n_q, sys_rst_n_q, pll_ok_q;
  logic             bump;

  always_comb begin
    state_d = state_q;
    bump    = 1'b0;
    case (state_q)
      PLL_RST:   if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock beats timeout when both land on the same cycle.
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          bump    = 1'b1;
        end
      end
      STABLE: begin
        // A drop on the terminal cycle still sends us back to WAIT_LOCK.
        if (!lock_s)                    state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          bump    = 1'b1;
        end
      end
      default: state_d = PLL_RST;
    endcase

    // Shared counter restarts on every state change; it is idle in RUN.
    if (state_d != state_q)  cnt_d = '0;
    else if (state_q == RUN) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CNT_W'(1);

    retry_d = (bump && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register, with no input-to-output combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      pll_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_n_q <= (state_d != PLL_RST);
      sys_rst_n_q <= (state_d == RUN);
      pll_ok_q    <= (state_d == RUN);
    end
  end

  assign pll_rst_n = pll_rst_n_q;
  assign sys_rst_n = sys_rst_n_q;
  assign pll_ok    = pll_ok_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_cam_pll_sup.sv
// Directed bench for cam_pll_sup with PLL_RST_CYCLES=4, LOCK_TIMEOUT=100,
// LOCK_STABLE=8. Edge numbers in comments count rising edges after rst_n
// is released, starting at 1. Outputs are sampled 1 ns after an edge.
module tb_cam_pll_sup;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_rst_n;
  logic       sys_rst_n;
  logic       pll_ok;
  logic [7:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  cam_pll_sup #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (100),
    .LOCK_STABLE    (8),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_rst_n (pll_rst_n),
    .sys_rst_n (sys_rst_n),
    .pll_ok    (pll_ok),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and release it mid-cycle.
  task automatic do_reset(input logic lock_val);
    @(negedge clk);
    rst_n    = 1'b0;
    pll_lock = lock_val;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_outs(input string tag, input logic prn, input logic srn,
                          input logic ok, input logic [7:0] rc);
    chk({tag, ".pll_rst_n"}, {7'd0, pll_rst_n}, {7'd0, prn});
    chk({tag, ".sys_rst_n"}, {7'd0, sys_rst_n}, {7'd0, srn});
    chk({tag, ".pll_ok"},    {7'd0, pll_ok},    {7'd0, ok});
    chk({tag, ".retry_cnt"}, retry_cnt, rc);
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b1;
    #2;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);

    // ---- Nominal: lock held high ----
    do_reset(1'b1);
    step(3);   chk_outs("nom_e3",  1'b0, 1'b0, 1'b0, 8'd0);
    step(1);   chk_outs("nom_e4",  1'b1, 1'b0, 1'b0, 8'd0);
    step(8);   chk_outs("nom_e12", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1);   chk_outs("nom_e13", 1'b1, 1'b1, 1'b1, 8'd0);

    // ---- Lock loss in RUN, then relock ----
    step(5);
    pll_lock = 1'b0;                     // falls between edges; next edge is k
    step(2);   chk_outs("loss_k1", 1'b1, 1'b1, 1'b1, 8'd0);
    step(1);   chk_outs("loss_k2", 1'b0, 1'b0, 1'b0, 8'd1);   // PLL_RST entry E
    pll_lock = 1'b1;
    step(4);   chk_outs("relock_e4",  1'b1, 1'b0, 1'b0, 8'd1);
    step(8);   chk_outs("relock_e12", 1'b1, 1'b0, 1'b0, 8'd1);
    step(1);   chk_outs("relock_e13", 1'b1, 1'b1, 1'b1, 8'd1);

    // ---- Async reset mid-RUN, between edges ----
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4);   chk_outs("restart_e4",  1'b1, 1'b0, 1'b0, 8'd0);
    step(9);   chk_outs("restart_e13", 1'b1, 1'b1, 1'b1, 8'd0);

    // ---- STABLE glitch: one-cycle drop lands on 5th STABLE cycle ----
    do_reset(1'b1);
    step(7);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(5);   chk_outs("glitch_e13", 1'b1, 1'b0, 1'b0, 8'd0);
    step(5);   chk_outs("glitch_e18", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1);   chk_outs("glitch_e19", 1'b1, 1'b1, 1'b1, 8'd0);

    // ---- Lock arrives exactly on the timeout cycle ----
    do_reset(1'b0);
    step(101);
    pll_lock = 1'b1;                     // lock_s first seen on cnt=99 cycle
    step(3);   chk_outs("tolock_e104", 1'b1, 1'b0, 1'b0, 8'd0);
    step(7);   chk_outs("tolock_e111", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1);   chk_outs("tolock_e112", 1'b1, 1'b1, 1'b1, 8'd0);

    // ---- Timeout retries and saturation, lock held low ----
    do_reset(1'b0);
    step(4);   chk_outs("to_e4",   1'b1, 1'b0, 1'b0, 8'd0);
    step(99);  chk_outs("to_e103", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1);   chk_outs("to_e104", 1'b0, 1'b0, 1'b0, 8'd1);
    step(3);   chk_outs("to_e107", 1'b0, 1'b0, 1'b0, 8'd1);
    step(1);   chk_outs("to_e108", 1'b1, 1'b0, 1'b0, 8'd1);
    step(100); chk_outs("to_e208", 1'b0, 1'b0, 1'b0, 8'd2);
    step(104 * 255 - 1 - 208);
               chk("sat_e26519.retry_cnt", retry_cnt, 8'd254);
    step(1);   chk("sat_e26520.retry_cnt", retry_cnt, 8'd255);
    step(104 * 45);
               chk_outs("sat_e31200", 1'b0, 1'b0, 1'b0, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
